// File: rtl/divider_scheduler.sv
// -----------------------------------------------------------------------------
// divider_scheduler
//
// Walks the CDF memory from bin 0 to BINS-1. For each bin it reads one CDF
// word, starts the divider with a one-cycle div_en pulse, waits for the
// divider result, and writes it into the equalisation LUT at the same bin
// index. If the divider does not respond within TIMEOUT cycles, the run stops
// in an error state with a sticky error flag.
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          synchronous, active-high reset
//   i_start          begin a run (accepted only in IDLE or ERR)
//   i_abort          cancel a running sequence (ignored when not busy)
//   o_busy           high in every state except IDLE and ERR
//   o_done           one-cycle pulse after the last bin has been written
//   o_error          sticky divider-timeout flag
//   o_cdf_rd_en      CDF memory read strobe
//   o_cdf_rd_addr    CDF read address
//   i_cdf_rd_data    CDF read data, valid one cycle after o_cdf_rd_en
//   o_div_enable     divider enable, equal to o_busy
//   o_div_en         divider start pulse, one per bin
//   o_div_cdf_in     divider operand
//   i_div_g_out      divider result
//   i_div_ready      divider result valid
//   o_lut_wr_en      LUT write strobe, one per bin
//   o_lut_wr_addr    LUT write address (bin index)
//   o_lut_wr_data    captured divider result
// -----------------------------------------------------------------------------
module divider_scheduler #(
  parameter int BINS    = 256,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_cdf_rd_en,
  output logic [ADDR_W-1:0] o_cdf_rd_addr,
  input  logic [DATA_W-1:0] i_cdf_rd_data,
  output logic              o_div_enable,
  output logic              o_div_en,
  output logic [DATA_W-1:0] o_div_cdf_in,
  input  logic [DATA_W-1:0] i_div_g_out,
  input  logic              i_div_ready,
  output logic              o_lut_wr_en,
  output logic [ADDR_W-1:0] o_lut_wr_addr,
  output logic [DATA_W-1:0] o_lut_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_ISSUE,
    S_WAIT_DIV,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(BINS - 1);

  state_t              r_state;
  state_t              w_state_n;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_n;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_operand;
  logic                w_busy;
  logic                w_accept;
  logic                w_capture_g;

  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_cdf_rd_en;
  logic [ADDR_W-1:0]   r_cdf_rd_addr;
  logic                r_div_en;
  logic                r_lut_wr_en;
  logic [ADDR_W-1:0]   r_lut_wr_addr;
  logic [DATA_W-1:0]   r_lut_wr_data;

  // Next-state and index logic.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_state_n   = r_state;
    w_idx_n     = r_idx;
    w_busy      = (r_state != S_IDLE) && (r_state != S_ERR);
    w_accept    = !w_busy && i_start;
    w_capture_g = 1'b0;

    if (w_busy && i_abort) begin
      w_state_n = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_ERR: begin
          if (i_start) begin
            w_state_n = S_RD_REQ;
            w_idx_n   = '0;
          end
        end
        S_RD_REQ:  w_state_n = S_RD_WAIT;
        S_RD_WAIT: w_state_n = S_ISSUE;
        S_ISSUE:   w_state_n = S_WAIT_DIV;
        S_WAIT_DIV: begin
          // A ready arriving on the last allowed cycle still wins over timeout.
          if (i_div_ready) begin
            w_state_n   = S_WRITE;
            w_capture_g = 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            w_state_n = S_ERR;
          end
        end
        S_WRITE: begin
          if (r_idx == IDX_LAST) begin
            w_state_n = S_DONE;
          end else begin
            w_state_n = S_RD_REQ;
            w_idx_n   = r_idx + ADDR_W'(1);
          end
        end
        S_DONE:  w_state_n = S_IDLE;
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // State, datapath and registered outputs. Strobes are decoded from the next
  // state so each one is high exactly while the FSM sits in its state.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_operand     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_cdf_rd_en   <= 1'b0;
      r_cdf_rd_addr <= '0;
      r_div_en      <= 1'b0;
      r_lut_wr_en   <= 1'b0;
      r_lut_wr_addr <= '0;
      r_lut_wr_data <= '0;
    end else begin
      r_state     <= w_state_n;
      r_idx       <= w_idx_n;
      r_busy      <= (w_state_n != S_IDLE) && (w_state_n != S_ERR);
      r_cdf_rd_en <= (w_state_n == S_RD_REQ);
      r_div_en    <= (w_state_n == S_ISSUE);
      r_lut_wr_en <= (w_state_n == S_WRITE);
      r_done      <= (w_state_n == S_DONE);

      if (w_state_n == S_RD_REQ) begin
        r_cdf_rd_addr <= w_idx_n;
      end
      if (w_state_n == S_WRITE) begin
        r_lut_wr_addr <= r_idx;
      end

      if (r_state == S_RD_WAIT) begin
        r_operand <= i_cdf_rd_data;
      end
      if (w_capture_g) begin
        r_lut_wr_data <= i_div_g_out;
      end

      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_DIV && !i_div_ready) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_accept) begin
        r_error <= 1'b0;
      end else if (r_state == S_WAIT_DIV && w_state_n == S_ERR) begin
        r_error <= 1'b1;
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_cdf_rd_en   = r_cdf_rd_en;
  assign o_cdf_rd_addr = r_cdf_rd_addr;
  assign o_div_enable  = r_busy;
  assign o_div_en      = r_div_en;
  // The operand only reloads in RD_WAIT, so it is stable from ISSUE to WRITE.
  assign o_div_cdf_in  = r_operand;
  assign o_lut_wr_en   = r_lut_wr_en;
  assign o_lut_wr_addr = r_lut_wr_addr;
  assign o_lut_wr_data = r_lut_wr_data;

endmodule

// File: tb/tb_divider_scheduler.sv
// -----------------------------------------------------------------------------
// tb_divider_scheduler
//
// Environment: a CDF memory with one-cycle read latency and a divider model
// with programmable latency. Expected LUT writes and done-pulse cycles are
// queued when a run is launched; a monitor on the falling edge pops and
// compares whenever the DUT writes the LUT or pulses done.
// -----------------------------------------------------------------------------
module tb_divider_scheduler;

  localparam int BINS    = 256;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic              o_busy;
  logic              o_done;
  logic              o_error;
  logic              o_cdf_rd_en;
  logic [ADDR_W-1:0] o_cdf_rd_addr;
  logic [DATA_W-1:0] cdf_rd_data;
  logic              o_div_enable;
  logic              o_div_en;
  logic [DATA_W-1:0] o_div_cdf_in;
  logic [DATA_W-1:0] div_g_out;
  logic              div_ready;
  logic              o_lut_wr_en;
  logic [ADDR_W-1:0] o_lut_wr_addr;
  logic [DATA_W-1:0] o_lut_wr_data;

  always #5 clk = ~clk;

  divider_scheduler #(
    .BINS   (BINS),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) u_dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_start      (start),
    .i_abort      (abort),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_cdf_rd_en  (o_cdf_rd_en),
    .o_cdf_rd_addr(o_cdf_rd_addr),
    .i_cdf_rd_data(cdf_rd_data),
    .o_div_enable (o_div_enable),
    .o_div_en     (o_div_en),
    .o_div_cdf_in (o_div_cdf_in),
    .i_div_g_out  (div_g_out),
    .i_div_ready  (div_ready),
    .o_lut_wr_en  (o_lut_wr_en),
    .o_lut_wr_addr(o_lut_wr_addr),
    .o_lut_wr_data(o_lut_wr_data)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Arbitrary but deterministic divider transfer function.
  function automatic logic [DATA_W-1:0] g_model(input logic [DATA_W-1:0] x);
    return (x / 32'd3) ^ 32'h5A00_00A5;
  endfunction

  // ---------------------------------------------------------------------------
  // Environment: CDF memory and divider
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] cdf_mem [BINS];
  int                div_lat;      // 0 means the divider never answers
  bit                spur_ready;   // force ready regardless of divider state

  initial begin : env
    bit                rd_pend;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] div_op;
    int                div_pend;
    rd_pend     = 1'b0;
    rd_addr_q   = '0;
    div_op      = '0;
    div_pend    = 0;
    cdf_rd_data = '0;
    div_ready   = 1'b0;
    div_g_out   = '0;
    forever begin
      @(posedge clk);
      #1;
      // Memory: data for a read strobe appears in the following cycle,
      // otherwise the bus carries junk.
      cdf_rd_data = rd_pend ? cdf_mem[rd_addr_q] : DATA_W'($urandom);
      rd_pend     = (o_cdf_rd_en === 1'b1);
      rd_addr_q   = o_cdf_rd_addr;
      // Divider: ready exactly div_lat cycles after the div_en cycle.
      div_ready = 1'b0;
      div_g_out = DATA_W'($urandom);
      if (div_pend > 0) begin
        div_pend--;
        if (div_pend == 0) begin
          div_ready = 1'b1;
          div_g_out = g_model(div_op);
        end
      end
      if (o_div_en === 1'b1) begin
        div_op   = o_div_cdf_in;
        div_pend = div_lat;
      end
      if (spur_ready) div_ready = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_wr[$];
  int  exp_done[$];
  int  div_en_seen;

  always @(negedge clk) begin : monitor
    wr_t e;
    int  n_strobe;
    if (reset === 1'b0) begin
      if (o_lut_wr_en === 1'b1) begin
        if (exp_wr.size() == 0) begin
          check("lut_wr_unexpected", o_lut_wr_en, 0);
        end else begin
          e = exp_wr.pop_front();
          check("lut_wr_addr", o_lut_wr_addr, e.addr);
          check("lut_wr_data", o_lut_wr_data, e.data);
        end
      end
      if (o_done === 1'b1) begin
        if (exp_done.size() == 0) check("done_unexpected", o_done, 0);
        else                      check("done_cycle", cyc, exp_done.pop_front());
      end
      n_strobe = int'(o_cdf_rd_en) + int'(o_div_en) + int'(o_lut_wr_en) + int'(o_done);
      if (n_strobe > 1) check("strobe_overlap", n_strobe, 1);
      if (o_div_en === 1'b1) div_en_seen++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < BINS; i++) cdf_mem[i] = DATA_W'($urandom);
    cdf_mem[0]      = '0;
    cdf_mem[BINS-1] = '1;
  endtask

  // Queue the writes of bins [0, n_bins) and optionally the done pulse, for a
  // run whose start is held during cycle c0.
  task automatic expect_run(input int c0, input int lat, input int n_bins, input bit with_done);
    wr_t e;
    for (int i = 0; i < n_bins; i++) begin
      e.addr = ADDR_W'(i);
      e.data = g_model(cdf_mem[i]);
      exp_wr.push_back(e);
    end
    if (with_done) exp_done.push_back(c0 + BINS * (4 + lat) + 1);
  endtask

  task automatic launch(input int lat);
    div_lat     = lat;
    div_en_seen = 0;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (o_busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_completes"}, o_busy, 0);
  endtask

  task automatic after_run(input string name, input int n_issue, input logic err);
    check({name, "_wr_left"}, exp_wr.size(), 0);
    check({name, "_done_left"}, exp_done.size(), 0);
    check({name, "_div_en_count"}, div_en_seen, n_issue);
    check({name, "_error"}, o_error, err);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : stim
    int c0;
    reset      = 1'b1;
    start      = 1'b1;
    abort      = 1'b0;
    div_lat    = 1;
    spur_ready = 1'b0;

    // Reset held with start high: everything quiet.
    repeat (3) tick();
    check("rst_ctrl", {o_busy, o_done, o_error, o_cdf_rd_en, o_div_enable, o_div_en,
                       o_lut_wr_en, o_cdf_rd_addr, o_lut_wr_addr}, 0);
    check("rst_div_cdf_in", o_div_cdf_in, 0);
    check("rst_lut_wr_data", o_lut_wr_data, 0);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) begin
      tick();
      check("post_rst_quiet", {o_busy, o_cdf_rd_en, o_div_en, o_lut_wr_en, o_done}, 0);
    end

    // Full run, divider latency 3.
    fill_mem();
    c0 = cyc;
    expect_run(c0, 3, BINS, 1'b1);
    launch(3);
    check("run_busy", {o_busy, o_div_enable}, 2'b11);
    wait_idle("lat3", 3000);
    after_run("lat3", BINS, 1'b0);

    // Divider never answers: timeout after TIMEOUT WAIT_DIV cycles.
    fill_mem();
    c0 = cyc;
    launch(0);
    while (cyc < c0 + 3 + TIMEOUT) tick();
    check("pre_timeout_state", {o_busy, o_error}, 2'b10);
    tick();
    check("timeout_state", {o_busy, o_error, o_div_enable}, 3'b010);
    repeat (5) tick();
    check("error_sticky", {o_busy, o_error}, 2'b01);
    after_run("timeout", 1, 1'b1);

    // Restart from ERR clears error and begins again at bin 0.
    c0 = cyc;
    expect_run(c0, 2, BINS, 1'b1);
    launch(2);
    check("restart_clears_error", {o_busy, o_error}, 2'b10);
    wait_idle("restart", 3000);
    after_run("restart", BINS, 1'b0);

    // Abort in the first WAIT_DIV cycle of bin 2; the late ready is ignored.
    fill_mem();
    c0 = cyc;
    expect_run(c0, 2, 2, 1'b0);
    launch(2);
    while (cyc < c0 + 1 + 2 * 6 + 3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_to_idle", {o_busy, o_div_enable}, 0);
    repeat (10) tick();
    after_run("abort", 3, 1'b0);

    // Ready pulsed while idle: nothing happens.
    spur_ready = 1'b1;
    repeat (3) tick();
    spur_ready = 1'b0;
    repeat (2) tick();
    check("idle_ready_ignored", {o_busy, o_lut_wr_en, o_div_en}, 0);

    // Ready on the timeout cycle wins; a mid-run start is ignored.
    fill_mem();
    c0 = cyc;
    expect_run(c0, TIMEOUT, BINS, 1'b1);
    launch(TIMEOUT);
    repeat (100 + int'($urandom_range(0, 40))) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("ready_at_timeout", 5000);
    after_run("ready_at_timeout", BINS, 1'b0);

    // Fastest divider: latency 1.
    fill_mem();
    c0 = cyc;
    expect_run(c0, 1, BINS, 1'b1);
    launch(1);
    wait_idle("lat1", 2000);
    after_run("lat1", BINS, 1'b0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
